// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller is the master: it consumes opcode/mem_ready and drives every
// datapath control line plus the debug/status outputs.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 16
);
  // Datapath -> controller
  logic [5:0]       opcode;
  logic             mem_ready;

  // Controller -> datapath
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;

  // Status / debug
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences FETCH -> DECODE -> per-class execute/memory/writeback states,
// drives Moore control outputs (a few gated by the memory handshake),
// counts retired instructions and flags unsupported opcodes.
module mips_multicycle_control #(
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  // Effective memory handshake: with MEM_WAIT cleared memory is always ready.
  logic rdy;

  // Ungated control decode; forced to 0 at the outputs while reset is held.
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       done, illegal;

  assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  // State register and retired-instruction counter; reset abandons any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state and Moore output decode; only FETCH/MEMRD/MEMWR look at rdy,
  // only DECODE/MEMADR look at opcode.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    done          = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed while the instruction word is read.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target (PC + imm<<2) is precomputed speculatively.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = rdy ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        // The store retires on the cycle memory accepts it.
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        done      = rdy;
        state_d   = rdy ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
        state_d   = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end

      // Unused codes recover to FETCH with every output at 0.
      default: state_d = S_FETCH;
    endcase

    instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, done};
  end

  // Outputs are held at 0 for as long as reset is asserted, even though the
  // state register already reads FETCH.
  assign bus.PCWrite     = rst_n & pc_write;
  assign bus.PCWriteCond = rst_n & pc_write_cond;
  assign bus.IorD        = rst_n & i_or_d;
  assign bus.MemRead     = rst_n & mem_read;
  assign bus.MemWrite    = rst_n & mem_write;
  assign bus.IRWrite     = rst_n & ir_write;
  assign bus.MemtoReg    = rst_n & mem_to_reg;
  assign bus.RegDst      = rst_n & reg_dst;
  assign bus.RegWrite    = rst_n & reg_write;
  assign bus.ALUSrcA     = rst_n & alu_src_a;
  assign bus.ALUSrcB     = {2{rst_n}} & alu_src_b;
  assign bus.ALUOp       = {2{rst_n}} & alu_op;
  assign bus.PCSource    = {2{rst_n}} & pc_source;
  assign bus.instr_done  = rst_n & done;
  assign bus.illegal_op  = rst_n & illegal;
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;

endmodule
